hamming_sec_scrubber: RTL and testbench



---
 rtl/hamming_sec_pkg.sv | 40 ++++
 rtl/hamming_sec_scrubber_if.sv | 23 ++
 rtl/hamming_sec_decoder.sv | 25 ++
 rtl/hamming_sec_encoder.sv | 9 +
 rtl/hamming_sec_scrubber.sv | 146 ++++++++++++++
 tb/tb_hamming_sec_scrubber.sv | 320 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/hamming_sec_pkg.sv
// Shared constants, FSM state codes and the 8->12 Hamming SEC encode function
// used by the scrubber, its encoder and its decoder.
package hamming_sec_pkg;

   localparam int unsigned CODE_W = 12;
   localparam int unsigned DATA_W = 8;

   // Parity bit positions within the codeword (positions 1,2,4,8 in 1-based terms)
   localparam int unsigned P0_POS = 0;
   localparam int unsigned P1_POS = 1;
   localparam int unsigned P2_POS = 3;
   localparam int unsigned P3_POS = 7;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StGap    = 3'd1;
   localparam logic [2:0] StRdReq  = 3'd2;
   localparam logic [2:0] StRdWait = 3'd3;
   localparam logic [2:0] StCheck  = 3'd4;
   localparam logic [2:0] StWrReq  = 3'd5;
   localparam logic [2:0] StNext   = 3'd6;

   function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] c;
      c         = '0;
      c[2]      = d[0];
      c[4]      = d[1];
      c[5]      = d[2];
      c[6]      = d[3];
      c[8]      = d[4];
      c[9]      = d[5];
      c[10]     = d[6];
      c[11]     = d[7];
      c[P0_POS] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
      c[P1_POS] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
      c[P2_POS] = c[4] ^ c[5] ^ c[6] ^ c[11];
      c[P3_POS] = c[8] ^ c[9] ^ c[10] ^ c[11];
      return c;
   endfunction

endpackage

// File: rtl/hamming_sec_scrubber_if.sv
// Memory-port bundle between the scrubber (master) and the RAM port arbiter (slave).
interface hamming_sec_scrubber_if
   import hamming_sec_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [CODE_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic [CODE_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rdata
   );
endinterface

// File: rtl/hamming_sec_decoder.sv
// Combinational 12->8 Hamming SEC decoder; syndromes 13-15 pass the raw data bits through.
module hamming_sec_decoder
   import hamming_sec_pkg::*;
(
   input  logic [CODE_W-1:0] in_code,
   output logic [DATA_W-1:0] out_data,
   output logic              error_corrected
);
   logic [3:0]        syndrome;
   logic [CODE_W-1:0] fixed;

   always_comb begin
      syndrome = {^(in_code & 12'hF80), ^(in_code & 12'h878),
                  ^(in_code & 12'h666), ^(in_code & 12'h555)};
      fixed           = in_code;
      error_corrected = 1'b0;
      // Syndrome is the 1-based position of the flipped bit
      if (syndrome != 4'd0 && syndrome <= 4'd12) begin
         fixed[syndrome - 4'd1] = ~in_code[syndrome - 4'd1];
         error_corrected        = 1'b1;
      end
      out_data = {fixed[11], fixed[10], fixed[9], fixed[8],
                  fixed[6], fixed[5], fixed[4], fixed[2]};
   end
endmodule

// File: rtl/hamming_sec_encoder.sv
// Combinational 8->12 Hamming SEC encoder, used to rebuild the write-back codeword.
module hamming_sec_encoder
   import hamming_sec_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] code_o
);
   assign code_o = hamming_encode(data_i);
endmodule

// File: rtl/hamming_sec_scrubber.sv
// Background scrubber: reads every word, writes back corrected codewords and
// keeps saturating corrected/uncorrectable counters for the CSR block.
module hamming_sec_scrubber
   import hamming_sec_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   clear_counts,
   hamming_sec_scrubber_if.master mem,
   output logic                   busy,
   output logic                   pass_done,
   output logic [CNT_W-1:0]       corr_count,
   output logic [CNT_W-1:0]       uncorr_count,
   output logic [ADDR_W-1:0]      last_err_addr,
   output logic                   last_err_valid
);
   localparam int unsigned      GAP_W     = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] wdata_q, wdata_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [CNT_W-1:0]  corr_q, corr_d;
   logic [CNT_W-1:0]  uncorr_q, uncorr_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              err_valid_q, err_valid_d;

   logic [DATA_W-1:0] dec_data;
   logic              dec_corr;
   logic [CODE_W-1:0] enc;

   hamming_sec_decoder u_dec (
      .in_code         (code_q),
      .out_data        (dec_data),
      .error_corrected (dec_corr)
   );

   hamming_sec_encoder u_enc (
      .data_i (dec_data),
      .code_o (enc)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      code_d      = code_q;
      wdata_d     = wdata_q;
      gap_d       = gap_q;
      corr_d      = corr_q;
      uncorr_d    = uncorr_q;
      err_addr_d  = err_addr_q;
      err_valid_d = err_valid_q;
      case (state_q)
         StIdle: if (enable) state_d = StRdReq;
         StGap: begin
            if (!enable)             state_d = StIdle;
            else if (gap_q <= GAP_W'(1)) state_d = StRdReq;
            else                     gap_d   = gap_q - GAP_W'(1);
         end
         StRdReq: if (mem.mem_gnt) state_d = StRdWait;
         StRdWait: begin
            code_d  = mem.mem_rdata;
            state_d = StCheck;
         end
         StCheck: begin
            if (dec_corr) begin
               wdata_d = enc;
               if (corr_q != '1) corr_d = corr_q + CNT_W'(1);
               state_d = StWrReq;
            end else begin
               // A clean word re-encodes to itself; anything else is a multi-bit error
               if (enc != code_q) begin
                  if (uncorr_q != '1) uncorr_d = uncorr_q + CNT_W'(1);
                  err_addr_d  = addr_q;
                  err_valid_d = 1'b1;
               end
               state_d = StNext;
            end
         end
         StWrReq: if (mem.mem_gnt) state_d = StNext;
         StNext: begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            if (!enable) begin
               state_d = StIdle;
            end else if (GAP_CYCLES == 0) begin
               state_d = StRdReq;
            end else begin
               state_d = StGap;
               gap_d   = GAP_LOAD;
            end
         end
         default: state_d = StIdle;
      endcase
      if (clear_counts) begin
         corr_d      = '0;
         uncorr_d    = '0;
         err_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         code_q      <= '0;
         wdata_q     <= '0;
         gap_q       <= '0;
         corr_q      <= '0;
         uncorr_q    <= '0;
         err_addr_q  <= '0;
         err_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         code_q      <= code_d;
         wdata_q     <= wdata_d;
         gap_q       <= gap_d;
         corr_q      <= corr_d;
         uncorr_q    <= uncorr_d;
         err_addr_q  <= err_addr_d;
         err_valid_q <= err_valid_d;
      end
   end

   // Request decodes straight from state_q so reset drops it without a clock edge
   assign mem.mem_req   = (state_q == StRdReq) || (state_q == StWrReq);
   assign mem.mem_we    = (state_q == StWrReq);
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign busy           = (state_q != StIdle);
   assign pass_done      = (state_q == StNext) && (addr_q == LAST_ADDR);
   assign corr_count     = corr_q;
   assign uncorr_count   = uncorr_q;
   assign last_err_addr  = err_addr_q;
   assign last_err_valid = err_valid_q;
endmodule

// File: tb/tb_hamming_sec_scrubber.sv
// Directed bench: clean pass, correction/uncorrectable handling, grant stalls,
// enable drop during write-back, counter saturation/clear, async reset and gap throttle.
`timescale 1ns/1ps
module tb_hamming_sec_scrubber;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CNT_W  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Main DUT: GAP_CYCLES = 0
   logic              enable = 1'b0;
   logic              clear_counts = 1'b0;
   logic              busy, pass_done, last_err_valid;
   logic [CNT_W-1:0]  corr_count, uncorr_count;
   logic [ADDR_W-1:0] last_err_addr;
   logic              gnt = 1'b1;

   hamming_sec_scrubber_if #(.ADDR_W(ADDR_W)) mif ();

   hamming_sec_scrubber #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GAP_CYCLES(0), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear_counts(clear_counts), .mem(mif),
      .busy(busy), .pass_done(pass_done), .corr_count(corr_count),
      .uncorr_count(uncorr_count), .last_err_addr(last_err_addr),
      .last_err_valid(last_err_valid)
   );

   // Gap DUT: GAP_CYCLES = 2, always-granted clean memory
   logic              enable_g = 1'b0;
   logic              busy_g, pass_done_g, last_err_valid_g;
   logic [CNT_W-1:0]  corr_count_g, uncorr_count_g;
   logic [ADDR_W-1:0] last_err_addr_g;

   hamming_sec_scrubber_if #(.ADDR_W(ADDR_W)) ifg ();
   assign ifg.mem_gnt   = 1'b1;
   assign ifg.mem_rdata = 12'h000;

   hamming_sec_scrubber #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GAP_CYCLES(2), .CNT_W(CNT_W)
   ) dut_g (
      .clk(clk), .rst(rst), .enable(enable_g), .clear_counts(1'b0), .mem(ifg),
      .busy(busy_g), .pass_done(pass_done_g), .corr_count(corr_count_g),
      .uncorr_count(uncorr_count_g), .last_err_addr(last_err_addr_g),
      .last_err_valid(last_err_valid_g)
   );

   // Memory model
   logic [11:0] mem [0:15];
   logic [11:0] rdata_q;
   int          wr_cnt, rd_cnt;
   logic [7:0]  last_wr_addr;
   logic [11:0] last_wr_data;
   logic        mem_clr = 1'b1;
   logic        poke_en = 1'b0;
   logic [3:0]  poke_addr = '0;
   logic [11:0] poke_data = '0;

   assign mif.mem_gnt   = gnt;
   assign mif.mem_rdata = rdata_q;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 12'h000;
         rdata_q      <= '0;
         wr_cnt       <= 0;
         rd_cnt       <= 0;
         last_wr_addr <= '0;
         last_wr_data <= '0;
      end else begin
         if (poke_en) mem[poke_addr] <= poke_data;
         if (mif.mem_req && mif.mem_gnt) begin
            if (mif.mem_we) begin
               mem[mif.mem_addr[3:0]] <= mif.mem_wdata;
               wr_cnt       <= wr_cnt + 1;
               last_wr_addr <= mif.mem_addr;
               last_wr_data <= mif.mem_wdata;
            end else begin
               rdata_q <= mem[mif.mem_addr[3:0]];
               rd_cnt  <= rd_cnt + 1;
            end
         end
      end
   end

   task automatic poke(input logic [3:0] a, input logic [11:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({mif.mem_req, mif.mem_we} !== 2'b00) begin failures++;
         $display("FAIL reset_req_we got=%b exp=00", {mif.mem_req, mif.mem_we}); end
      checks++; if (mif.mem_addr !== 8'h00) begin failures++;
         $display("FAIL reset_addr got=%0h exp=0", mif.mem_addr); end
      checks++; if (mif.mem_wdata !== 12'h000) begin failures++;
         $display("FAIL reset_wdata got=%0h exp=0", mif.mem_wdata); end
      checks++; if ({busy, pass_done, last_err_valid} !== 3'b000) begin failures++;
         $display("FAIL reset_flags got=%b exp=000", {busy, pass_done, last_err_valid}); end
      checks++; if ({corr_count, uncorr_count, last_err_addr} !== 12'h000) begin failures++;
         $display("FAIL reset_counts got=%0h exp=0", {corr_count, uncorr_count, last_err_addr}); end
      mem_clr = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clean_pass();
      int rd = 0, pd_at = 0, wr0;
      wr0    = wr_cnt;
      enable = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (mif.mem_req && !mif.mem_we && gnt) rd++;
         if (pass_done) begin pd_at = n; enable = 1'b0; break; end
      end
      checks++; if (pd_at !== 64) begin failures++;
         $display("FAIL clean_pass_done_cycle got=%0d exp=64", pd_at); end
      checks++; if (rd !== 16) begin failures++;
         $display("FAIL clean_reads got=%0d exp=16", rd); end
      checks++; if (wr_cnt - wr0 !== 0) begin failures++;
         $display("FAIL clean_writes got=%0d exp=0", wr_cnt - wr0); end
      checks++; if ({corr_count, uncorr_count} !== 4'h0) begin failures++;
         $display("FAIL clean_counts got=%0h exp=0", {corr_count, uncorr_count}); end
      @(negedge clk);
      checks++; if ({busy, pass_done, mif.mem_addr} !== 10'h000) begin failures++;
         $display("FAIL clean_idle_wrap got=%0h exp=0", {busy, pass_done, mif.mem_addr}); end
   endtask

   task automatic test_correct_uncorrect();
      int pd_at = 0, wr0;
      poke(4'd5, 12'hA67);
      poke(4'd9, 12'h226);
      wr0    = wr_cnt;
      enable = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (pass_done) begin pd_at = n; enable = 1'b0; break; end
      end
      checks++; if (pd_at !== 65) begin failures++;
         $display("FAIL corr_pass_done_cycle got=%0d exp=65", pd_at); end
      checks++; if (wr_cnt - wr0 !== 1) begin failures++;
         $display("FAIL corr_write_count got=%0d exp=1", wr_cnt - wr0); end
      checks++; if ({last_wr_addr, last_wr_data} !== {8'h05, 12'hA27}) begin failures++;
         $display("FAIL corr_write got=%0h/%0h exp=5/a27", last_wr_addr, last_wr_data); end
      checks++; if (mem[5] !== 12'hA27) begin failures++;
         $display("FAIL corr_mem5 got=%0h exp=a27", mem[5]); end
      checks++; if (corr_count !== 2'd1) begin failures++;
         $display("FAIL corr_count got=%0d exp=1", corr_count); end
      checks++; if (uncorr_count !== 2'd1) begin failures++;
         $display("FAIL uncorr_count got=%0d exp=1", uncorr_count); end
      checks++; if ({last_err_valid, last_err_addr} !== {1'b1, 8'h09}) begin failures++;
         $display("FAIL uncorr_err_addr got=%b/%0h exp=1/9", last_err_valid, last_err_addr); end
      checks++; if (mem[9] !== 12'h226) begin failures++;
         $display("FAIL uncorr_no_write got=%0h exp=226", mem[9]); end
      @(negedge clk);
      poke(4'd9, 12'h000);
   endtask

   task automatic test_gnt_stall();
      logic found = 1'b0, stable;
      int   rd0;
      enable = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (mif.mem_req && mif.mem_addr == 8'd3) begin found = 1'b1; break; end
      end
      gnt = 1'b0;
      rd0 = rd_cnt;
      checks++; if (found !== 1'b1) begin failures++;
         $display("FAIL stall_reach_addr3 got=%b exp=1", found); end
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         stable = mif.mem_req && !mif.mem_we && (mif.mem_addr == 8'd3);
         checks++; if (stable !== 1'b1) begin failures++;
            $display("FAIL stall_hold got=%b/%b/%0h exp=1/0/3", mif.mem_req, mif.mem_we,
                     mif.mem_addr); end
      end
      gnt = 1'b1;
      @(negedge clk);
      checks++; if ({mif.mem_req, rd_cnt - rd0} !== {1'b0, 32'd1}) begin failures++;
         $display("FAIL stall_read_after_gnt got=%b/%0d exp=0/1", mif.mem_req, rd_cnt - rd0); end
   endtask

   task automatic test_enable_drop_write();
      logic found = 1'b0, held = 1'b1;
      logic [7:0] first_addr = 8'hFF;
      poke(4'd7, 12'hA67);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (mif.mem_req && !mif.mem_we && mif.mem_addr == 8'd7) begin found = 1'b1; break; end
      end
      @(negedge clk);
      gnt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({found, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata}
                    !== {3'b111, 8'h07, 12'hA27}) begin failures++;
         $display("FAIL wr_req got=%b%b%b/%0h/%0h exp=111/7/a27", found, mif.mem_req,
                  mif.mem_we, mif.mem_addr, mif.mem_wdata); end
      enable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (!(mif.mem_req && mif.mem_we)) held = 1'b0;
      end
      checks++; if (held !== 1'b1) begin failures++;
         $display("FAIL wr_hold_after_disable got=%b exp=1", held); end
      gnt = 1'b1;
      @(negedge clk);
      checks++; if ({busy, mem[7]} !== {1'b1, 12'hA27}) begin failures++;
         $display("FAIL wr_completed got=%b/%0h exp=1/a27", busy, mem[7]); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++;
         $display("FAIL wr_then_idle got=%b exp=0", busy); end
      enable = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (mif.mem_req) begin first_addr = mif.mem_addr; break; end
      end
      checks++; if (first_addr !== 8'd8) begin failures++;
         $display("FAIL resume_addr got=%0h exp=8", first_addr); end
   endtask

   task automatic test_saturate_clear();
      int   wr0;
      logic found = 1'b0;
      wr0 = wr_cnt;
      for (int a = 10; a <= 14; a++) poke(4'(a), 12'hA67);
      poke(4'd0, 12'hA67);
      clear_counts = 1'b1;
      @(negedge clk);
      clear_counts = 1'b0;
      checks++; if ({corr_count, uncorr_count, last_err_valid} !== 5'b0) begin failures++;
         $display("FAIL clear_counts got=%0d/%0d/%b exp=0/0/0", corr_count, uncorr_count,
                  last_err_valid); end
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (pass_done) break;
      end
      checks++; if (corr_count !== 2'd3) begin failures++;
         $display("FAIL saturate got=%0d exp=3", corr_count); end
      checks++; if (wr_cnt - wr0 !== 5) begin failures++;
         $display("FAIL saturate_writes got=%0d exp=5", wr_cnt - wr0); end
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (mif.mem_req && !mif.mem_we && mif.mem_addr == 8'd0) begin found = 1'b1; break; end
      end
      @(negedge clk);
      gnt = 1'b0;
      @(negedge clk);
      clear_counts = 1'b1;
      @(negedge clk);
      clear_counts = 1'b0;
      checks++; if ({found, mif.mem_req, mif.mem_we, corr_count} !== 5'b11100) begin
         failures++;
         $display("FAIL clear_priority got=%b%b%b/%0d exp=111/0", found, mif.mem_req,
                  mif.mem_we, corr_count); end
   endtask

   task automatic test_async_rst();
      int wr0;
      wr0 = wr_cnt;
      #2 rst = 1'b1;
      #1;
      checks++; if ({mif.mem_req, mif.mem_we, busy} !== 3'b000) begin failures++;
         $display("FAIL async_rst_req got=%b%b%b exp=000", mif.mem_req, mif.mem_we, busy); end
      enable = 1'b0;
      @(negedge clk);
      gnt = 1'b1;
      @(negedge clk);
      checks++; if ({mem[0], wr_cnt - wr0} !== {12'hA67, 32'd0}) begin failures++;
         $display("FAIL async_rst_write_abandoned got=%0h/%0d exp=a67/0", mem[0], wr_cnt - wr0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_gap();
      int         r1 = 0, r2 = 0;
      logic [7:0] a2 = 8'hFF;
      enable_g = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (ifg.mem_req && r1 == 0) r1 = n;
         else if (ifg.mem_req && r2 == 0) begin r2 = n; a2 = ifg.mem_addr; break; end
      end
      repeat (4) @(negedge clk);
      enable_g = 1'b0;
      @(negedge clk);
      checks++; if (r1 !== 1) begin failures++;
         $display("FAIL gap_first_read got=%0d exp=1", r1); end
      checks++; if (r2 - r1 !== 6) begin failures++;
         $display("FAIL gap_period got=%0d exp=6", r2 - r1); end
      checks++; if (a2 !== 8'd1) begin failures++;
         $display("FAIL gap_second_addr got=%0h exp=1", a2); end
      checks++; if (busy_g !== 1'b0) begin failures++;
         $display("FAIL gap_disable_idle got=%b exp=0", busy_g); end
   endtask

   initial begin
      test_reset();
      test_clean_pass();
      test_correct_uncorrect();
      test_gnt_stall();
      test_enable_drop_write();
      test_saturate_clear();
      test_async_rst();
      test_gap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
